// File: rtl/accum_decim_pkg.sv
// Shared helpers for the box-car accumulate-and-decimate stream block.
package accum_decim_pkg;

  localparam int unsigned EXT_MAX_W = 64;

  // Accumulator width: N = 2**log_cnt samples of din_w bits sum exactly here.
  function automatic int unsigned acc_width(input int unsigned din_w,
                                            input int unsigned log_cnt);
    return din_w + log_cnt;
  endfunction

  // Sign- or zero-extend the low din_w bits of data to EXT_MAX_W bits.
  function automatic logic [EXT_MAX_W-1:0] extend(input logic [EXT_MAX_W-1:0] data,
                                                  input int unsigned          din_w,
                                                  input bit                   is_signed);
    logic [EXT_MAX_W-1:0] mask;
    logic                 sign;
    mask = (EXT_MAX_W'(1) << din_w) - EXT_MAX_W'(1);
    sign = is_signed && ((data & (EXT_MAX_W'(1) << (din_w - 1))) != '0);
    return (data & mask) | (sign ? ~mask : '0);
  endfunction

endpackage

// File: rtl/dti_out_reg.sv
// Single-slot valid/ready output register; accepts a load in the same cycle it unloads.
module dti_out_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         can_load_c,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  // Slot is free when empty or being drained this cycle.
  assign can_load_c = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_decim.sv
// Sums each group of 2**LOG_CNT input samples and emits one widened result per group.
module accum_decim
  import accum_decim_pkg::*;
#(
  parameter int unsigned DIN     = 16,
  parameter int unsigned LOG_CNT = 2,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic [DIN-1:0]         din_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [DIN+LOG_CNT-1:0] dout_data
);

  localparam int unsigned AW = acc_width(DIN, LOG_CNT);

  logic [AW-1:0]      acc;
  logic [AW-1:0]      ext;
  logic [AW-1:0]      sum;
  logic [LOG_CNT-1:0] cnt;
  logic               last;
  logic               accept;
  logic               can_load;

  assign ext    = AW'(extend(EXT_MAX_W'(din_data), DIN, SIGNED));
  assign sum    = acc + ext;
  assign last   = &cnt;
  // Only the group-closing sample needs room in the output slot.
  assign din_ready = !last || can_load;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + LOG_CNT'(1);
      end
    end
  end

  dti_out_reg #(
    .W (AW)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (accept && last),
    .load_data  (sum),
    .can_load_c (can_load),
    .valid      (dout_valid),
    .ready      (dout_ready),
    .data       (dout_data)
  );

endmodule

// File: tb/tb_accum_decim.sv
// Self-checking bench for accum_decim: directed cases plus randomized valid/ready traffic.
module tb_accum_decim;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] din_data = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [17:0] dout_data;

  logic        s_din_valid = 1'b0;
  logic        s_din_ready;
  logic [15:0] s_din_data = '0;
  logic        s_dout_valid;
  logic        s_dout_ready = 1'b1;
  logic [17:0] s_dout_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  accum_decim #(.DIN(16), .LOG_CNT(2), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
  );

  accum_decim #(.DIN(16), .LOG_CNT(2), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst),
    .din_valid(s_din_valid), .din_ready(s_din_ready), .din_data(s_din_data),
    .dout_valid(s_dout_valid), .dout_ready(s_dout_ready), .dout_data(s_dout_data)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pending samples of the open group and the expected output slot.
  logic [15:0] grp[$];
  logic        m_v = 1'b0;
  logic [17:0] m_d = '0;
  logic        stall_prev = 1'b0;
  logic [17:0] prev_d = '0;
  int          groups = 0;
  int          outs = 0;

  function automatic logic [17:0] group_sum();
    longint s = 0;
    foreach (grp[i]) s += longint'(grp[i]);
    return 18'(s);
  endfunction

  always @(posedge clk) begin
    logic m_ready;
    logic closed;
    if (rst) begin
      grp.delete();
      m_v = 1'b0;
      m_d = '0;
      stall_prev = 1'b0;
    end else begin
      m_ready = (grp.size() != N - 1) || !m_v || dout_ready;
      chk("din_ready", 32'(din_ready), 32'(m_ready));
      chk("dout_valid", 32'(dout_valid), 32'(m_v));
      chk("dout_data", 32'(dout_data), 32'(m_d));
      if (stall_prev) chk("stall_hold", 32'(dout_data), 32'(prev_d));
      if (dout_valid && dout_ready) outs++;
      closed = 1'b0;
      if (din_valid && m_ready) begin
        grp.push_back(din_data);
        if (grp.size() == N) begin
          m_d = group_sum();
          groups++;
          grp.delete();
          closed = 1'b1;
        end
      end
      if (closed) m_v = 1'b1;
      else if (m_v && dout_ready) m_v = 1'b0;
      stall_prev = dout_valid && !dout_ready;
      prev_d = dout_data;
    end
  end

  // Present one sample from a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [15:0] d, output int stalls);
    stalls = 0;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    din_valid = 1'b1;
    din_data  = d;
    #1;
    while (!din_ready && stalls < 200) begin
      @(negedge clk);
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
      #1;
      stalls++;
    end
    if (!din_ready) chk("send_timeout", 32'(din_ready), 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int total;
    logic [15:0] sv [4];
    sv = '{16'hFFF0, 16'h0010, 16'hFFF0, 16'hFFF0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_data", 32'(dout_data), 32'd0);
    chk("reset_ready", 32'(din_ready), 32'd1);
    chk("s_reset_valid", 32'(s_dout_valid), 32'd0);
    chk("s_reset_data", 32'(s_dout_data), 32'd0);

    // Basic unsigned group
    total = 0;
    send(16'h0100, st); total += st;
    send(16'h0200, st); total += st;
    send(16'h0300, st); total += st;
    chk("grp1_not_yet", 32'(dout_valid), 32'd0);
    send(16'h0400, st); total += st;
    chk("grp1_valid", 32'(dout_valid), 32'd1);
    chk("grp1_sum", 32'(dout_data), 32'h00A00);
    chk("grp1_no_stall", 32'(total), 32'd0);

    // Signed group: -16 + 16 - 16 - 16 = -32
    for (int i = 0; i < 4; i++) begin
      s_din_valid = 1'b1;
      s_din_data  = sv[i];
      #1;
      chk("s_din_ready", 32'(s_din_ready), 32'd1);
      @(negedge clk);
    end
    s_din_valid = 1'b0;
    chk("s_valid", 32'(s_dout_valid), 32'd1);
    chk("s_sum", 32'(s_dout_data), 32'h3FFE0);

    // Backpressure: only the closing sample of the next group stalls
    @(negedge clk);
    dout_ready = 1'b0;
    send(16'h0001, st); send(16'h0002, st); send(16'h0003, st); send(16'h0004, st);
    chk("bp_first_valid", 32'(dout_valid), 32'd1);
    chk("bp_first_sum", 32'(dout_data), 32'h0000A);
    send(16'h0010, st); send(16'h0020, st); send(16'h0030, st);
    chk("bp_hold_valid", 32'(dout_valid), 32'd1);
    chk("bp_hold_data", 32'(dout_data), 32'h0000A);
    din_valid = 1'b1;
    din_data  = 16'h0040;
    #1;
    chk("bp_last_stall", 32'(din_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("bp_still_stall", 32'(din_ready), 32'd0);
    chk("bp_still_data", 32'(dout_data), 32'h0000A);
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    din_valid = 1'b0;
    chk("bp_second_valid", 32'(dout_valid), 32'd1);
    chk("bp_second_sum", 32'(dout_data), 32'h000A0);

    // Full-scale input, two groups back to back
    total = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'hFFFF, st);
      total += st;
      if (i == 3 || i == 7) begin
        chk("max_valid", 32'(dout_valid), 32'd1);
        chk("max_sum", 32'(dout_data), 32'h3FFFC);
      end
    end
    chk("max_no_stall", 32'(total), 32'd0);

    // Reset drops a pending result
    @(negedge clk);
    dout_ready = 1'b0;
    repeat (4) send(16'h0005, st);
    chk("drop_pending", 32'(dout_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("drop_valid", 32'(dout_valid), 32'd0);
    chk("drop_data", 32'(dout_data), 32'd0);

    // Reset mid-group discards the partial sum
    dout_ready = 1'b1;
    send(16'h0010, st);
    send(16'h0010, st);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) send(16'h0001, st);
    chk("part_valid", 32'(dout_valid), 32'd1);
    chk("part_sum", 32'(dout_data), 32'h00004);

    // Randomized valid/ready traffic
    @(negedge clk);
    @(negedge clk);
    groups = 0;
    outs   = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        dout_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      send(16'($urandom), st);
    end
    rand_ready = 1'b0;
    dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rand_groups", 32'(groups), 32'd250);
    chk("rand_outs", 32'(outs), 32'(groups));
    chk("rand_idle", 32'(dout_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
